alu_op_seq: RTL

Operand/command sequencer that drives the 4-bit ALU from board switches and a single step button. It synchronizes and debounces the button, steps a state machine through operand A, operand B and opcode entry, presents the latched operands to the ALU, and registers the ALU result and flags for display. It sits between the board I/O and the ALU; the ALU is its responder, and the registered result feeds the seven-segment display logic.

---
 rtl/alu_op_seq_if.sv | 28 ++
 rtl/alu_op_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_op_seq_if.sv
// ALU operand/result bus between the step sequencer (master) and the 4-bit ALU.
// The sequencer drives operands and opcode; the ALU returns result and flags.
interface alu_op_seq_if;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_res;
    logic       alu_car;
    logic       alu_of;

    modport master (
        output alu_a,
        output alu_b,
        output alu_ctrl,
        input  alu_res,
        input  alu_car,
        input  alu_of
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_ctrl,
        output alu_res,
        output alu_car,
        output alu_of
    );
endinterface

// File: rtl/alu_op_seq.sv
// Step-button driven operand/opcode sequencer for the 4-bit ALU.
// Debounces step/clear buttons, latches A, B and opcode, captures result.
module alu_op_seq #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       sw,
    input  logic [2:0]       sw_op,
    input  logic             btn_step,
    input  logic             btn_clr,
    alu_op_seq_if.master     alu,
    output logic [3:0]       res_q,
    output logic             car_q,
    output logic             of_q,
    output logic             res_valid,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] op_cnt
);
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] CMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DONE = DW'(1);
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t     state_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] ctrl_q;

    // Index 0 is the step button, index 1 the clear button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [1:0]    debp_q;
    logic [DW-1:0] cnt_q [2];
    logic [1:0]    pulse;
    logic          step_p;
    logic          clr_p;

    assign btn_raw = {btn_clr, btn_step};
    assign pulse   = deb_q & ~debp_q;
    assign step_p  = pulse[0];
    assign clr_p   = pulse[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            debp_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            debp_q  <= deb_q;
            // Count only while the synchronized level disagrees.
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CMAX) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            res_q     <= '0;
            car_q     <= 1'b0;
            of_q      <= 1'b0;
            res_valid <= 1'b0;
            op_cnt    <= '0;
        end else if (clr_p) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            res_q     <= '0;
            car_q     <= 1'b0;
            of_q      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state_q)
                S_A: if (step_p) begin
                    a_q       <= sw;
                    res_valid <= 1'b0;
                    state_q   <= S_B;
                end
                S_B: if (step_p) begin
                    b_q     <= sw;
                    state_q <= S_OP;
                end
                S_OP: if (step_p) begin
                    ctrl_q  <= sw_op;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    res_q     <= alu.alu_res;
                    car_q     <= alu.alu_car;
                    of_q      <= alu.alu_of;
                    res_valid <= 1'b1;
                    op_cnt    <= op_cnt + CONE;
                    state_q   <= S_SHOW;
                end
                S_SHOW: if (step_p) begin
                    state_q <= S_A;
                end
                default: state_q <= S_A;
            endcase
        end
    end

    assign alu.alu_a    = a_q;
    assign alu.alu_b    = b_q;
    assign alu.alu_ctrl = ctrl_q;
    assign state_o      = state_q;
endmodule
